// File: rtl/constraint_45_gen.sv
// Legal-only stimulus producer for constraint_45: draws (var_87, var_88) from a Galois LFSR,
// drops pairs violating !var_87 || var_88, and hands the rest out over valid/ready.
module constraint_45_gen #(
  parameter logic [31:0] SEED = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gen_en,
  input  logic        seed_load,
  input  logic [31:0] seed_val,
  input  logic        clr_cnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_var_87,
  output logic [7:0]  out_var_88,
  output logic [15:0] acc_cnt,
  output logic [15:0] rej_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [31:0] POLY    = 32'h8020_0003;
  localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_lfsr;
  logic        r_valid;
  logic [12:0] r_var_87;
  logic [7:0]  r_var_88;
  logic [15:0] r_acc;
  logic [15:0] r_rej;

  logic [12:0] w_c87;
  logic [7:0]  w_c88;
  logic        w_legal;
  logic        w_adv;
  logic        w_capture;
  logic        w_rej_inc;
  logic        w_acc_inc;

  assign w_c87   = r_lfsr[12:0];
  assign w_c88   = r_lfsr[20:13];
  assign w_legal = (w_c87 == 13'h0) || (w_c88 != 8'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // seed_load overrides every state, discarding any pair still in HOLD
  always_comb begin
    w_next = r_state;
    if (seed_load) begin
      w_next = gen_en ? DRAW : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (gen_en) w_next = DRAW;
        DRAW: begin
          if (!gen_en)      w_next = IDLE;
          else if (w_legal) w_next = HOLD;
        end
        HOLD:    if (out_ready) w_next = gen_en ? DRAW : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_adv     = 1'b0;
    w_capture = 1'b0;
    w_rej_inc = 1'b0;
    w_acc_inc = 1'b0;
    if (!seed_load) begin
      w_adv     = (r_state == DRAW) && gen_en;
      w_capture = w_adv && w_legal;
      w_rej_inc = w_adv && !w_legal;
      w_acc_inc = (r_state == HOLD) && out_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr   <= SEED_NZ;
      r_valid  <= 1'b0;
      r_var_87 <= 13'h0;
      r_var_88 <= 8'h0;
    end else begin
      if (seed_load)  r_lfsr <= (seed_val == 32'h0) ? 32'h1 : seed_val;
      else if (w_adv) r_lfsr <= lfsr_step(r_lfsr);

      if (seed_load)      r_valid <= 1'b0;
      else if (w_capture) r_valid <= 1'b1;
      else if (w_acc_inc) r_valid <= 1'b0;

      if (w_capture) begin
        r_var_87 <= w_c87;
        r_var_88 <= w_c88;
      end
    end
  end

  // A clear in the same cycle as an increment wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 16'h0;
      r_rej <= 16'h0;
    end else if (clr_cnt) begin
      r_acc <= 16'h0;
      r_rej <= 16'h0;
    end else begin
      if (w_acc_inc) r_acc <= r_acc + 16'd1;
      if (w_rej_inc) r_rej <= sat_inc(r_rej);
    end
  end

  assign out_valid  = r_valid;
  assign out_var_87 = r_var_87;
  assign out_var_88 = r_var_88;
  assign acc_cnt    = r_acc;
  assign rej_cnt    = r_rej;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_constraint_45_gen.sv
// Bench for constraint_45_gen: behavioural model compared every cycle, plus literal checks.
module tb_constraint_45_gen;

  localparam logic [31:0] SEED = 32'hACE1_2345;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        gen_en = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed_val = 32'h0;
  logic        clr_cnt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [12:0] out_var_87;
  logic [7:0]  out_var_88;
  logic [15:0] acc_cnt;
  logic [15:0] rej_cnt;
  logic        busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  constraint_45_gen #(.SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .gen_en(gen_en), .seed_load(seed_load),
    .seed_val(seed_val), .clr_cnt(clr_cnt), .out_valid(out_valid),
    .out_ready(out_ready), .out_var_87(out_var_87), .out_var_88(out_var_88),
    .acc_cnt(acc_cnt), .rej_cnt(rej_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 drawing, 2 holding a pair
  longint m_lfsr;
  int     m_mode, m_87, m_88, m_acc, m_rej;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= longint'(SEED);
      m_mode <= 0; m_87 <= 0; m_88 <= 0; m_acc <= 0; m_rej <= 0;
    end else begin : step
      int c87, c88;
      bit acc_ev, rej_ev;
      c87 = int'(m_lfsr % 8192);
      c88 = int'((m_lfsr / 8192) % 256);
      acc_ev = 1'b0;
      rej_ev = 1'b0;
      if (seed_load) begin
        m_lfsr <= (seed_val == 32'h0) ? 64'd1 : longint'(seed_val);
        m_mode <= gen_en ? 1 : 0;
      end else if (m_mode == 0) begin
        if (gen_en) m_mode <= 1;
      end else if (m_mode == 1) begin
        if (!gen_en) m_mode <= 0;
        else begin
          if (c87 == 0 || c88 != 0) begin
            m_87 <= c87; m_88 <= c88; m_mode <= 2;
          end else rej_ev = 1'b1;
          m_lfsr <= (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 64'h8020_0003 : 64'd0);
        end
      end else if (out_ready) begin
        acc_ev = 1'b1;
        m_mode <= gen_en ? 1 : 0;
      end
      if (clr_cnt) begin
        m_acc <= 0; m_rej <= 0;
      end else begin
        if (acc_ev) m_acc <= (m_acc + 1) % 65536;
        if (rej_ev && m_rej < 65535) m_rej <= m_rej + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, (m_mode == 2) ? 1 : 0);
      check("out_var_87", out_var_87, m_87);
      check("out_var_88", out_var_88, m_88);
      check("acc_cnt", acc_cnt, m_acc);
      check("rej_cnt", rej_cnt, m_rej);
      check("busy", busy, (m_mode != 0) ? 1 : 0);
      if (out_valid) check("pair_legal", (out_var_87 == 0 || out_var_88 != 0) ? 1 : 0, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int i;
    for (i = 0; i < 60 && !out_valid; i++) tick();
    if (!out_valid) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_valid"}, out_valid, 0);
    check({nm, "_v87"}, out_var_87, 0);
    check({nm, "_v88"}, out_var_88, 0);
    check({nm, "_acc"}, acc_cnt, 0);
    check({nm, "_rej"}, rej_cnt, 0);
    check({nm, "_busy"}, busy, 0);
  endtask

  // Seed 1 and seed 0 both give two rejects then the pair (0x0002, 0x80)
  task automatic run_seed(input logic [31:0] sv, input string nm);
    seed_load = 1'b1; seed_val = sv; gen_en = 1'b1; out_ready = 1'b0; clr_cnt = 1'b1;
    tick();
    seed_load = 1'b0; clr_cnt = 1'b0;
    tick(); tick(); tick();
    check({nm, "_valid_lat"}, out_valid, 1);
    check({nm, "_v87"}, out_var_87, 13'h0002);
    check({nm, "_v88"}, out_var_88, 8'h80);
    check({nm, "_rej"}, rej_cnt, 2);
    check({nm, "_acc0"}, acc_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check({nm, "_bp_valid"}, out_valid, 1);
      check({nm, "_bp_v87"}, out_var_87, 13'h0002);
      check({nm, "_bp_v88"}, out_var_88, 8'h80);
      check({nm, "_bp_acc"}, acc_cnt, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_hs_acc"}, acc_cnt, 1);
    check({nm, "_hs_valid"}, out_valid, 0);
  endtask

  initial begin
    int n, cyc;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gen_en = 1'($urandom); seed_load = 1'($urandom); seed_val = $urandom;
      clr_cnt = 1'($urandom); out_ready = 1'($urandom);
      tick();
      check_reset_vals("rst_hold");
    end
    gen_en = 1'b0; seed_load = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_busy", busy, 0);
    end

    run_seed(32'h1, "seed1");
    run_seed(32'h0, "seed0");

    // clear beats the simultaneous handshake increment
    wait_valid("prio_a");
    out_ready = 1'b1; clr_cnt = 1'b1;
    tick();
    out_ready = 1'b0; clr_cnt = 1'b0;
    check("clr_vs_hs_acc", acc_cnt, 0);
    wait_valid("prio_b");
    seed_load = 1'b1; seed_val = $urandom; out_ready = 1'b1;
    tick();
    seed_load = 1'b0; out_ready = 1'b0;
    check("seed_in_hold_valid", out_valid, 0);
    check("seed_in_hold_acc", acc_cnt, 0);

    // random control mix, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      gen_en = ($urandom_range(0, 9) != 0);
      out_ready = 1'($urandom);
      seed_load = ($urandom_range(0, 99) == 0);
      seed_val = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      clr_cnt = ($urandom_range(0, 99) == 0);
      tick();
    end

    // long stream of legal pairs
    gen_en = 1'b1; seed_load = 1'b0; out_ready = 1'b0; clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n = 0; cyc = 0;
    while (n < 10000 && cyc < 80000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) n++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("stream_pairs", n, 10000);
    check("stream_acc", acc_cnt, 10000);

    // asynchronous reset in mid-stream
    for (int i = 0; i < 7; i++) begin
      out_ready = 1'($urandom);
      tick();
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    tick();
    check_reset_vals("async_rst_hold");
    gen_en = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
